alu_exec_unit: RTL and testbench

Multi-cycle execute unit that consumes the 5-bit ALU control code produced by the ALU control decoder and carries out the selected operation on two operands. Single-cycle ops (ADD, SUB, AND, OR, SLT) finish in one cycle. With the M extension compiled in, MUL, DIV, DIVU, REM and REMU run on an iterative 1-bit-per-cycle datapath. It sits in the EX stage of the multi-cycle datapath. The control FSM stalls on `oBusy` and latches `oResult` when `oDone` is high.

---
 rtl/alu_exec_unit_pkg.sv | 57 +++++
 rtl/alu_exec_unit_if.sv | 17 +
 rtl/alu_iter_muldiv.sv | 82 ++++++++
 rtl/alu_exec_unit.sv | 149 ++++++++++++++
 tb/tb_alu_exec_unit.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/alu_exec_unit_pkg.sv
// Shared parameters for the EX-stage execute unit: widths, ALU control
// opcodes, FSM state encoding and single-cycle ALU helpers.
`ifndef PARAM
`define PARAM
package alu_exec_unit_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned OP_W  = 5;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [OP_W-1:0] OPAND  = 5'd0;
  localparam logic [OP_W-1:0] OPOR   = 5'd1;
  localparam logic [OP_W-1:0] OPADD  = 5'd2;
  localparam logic [OP_W-1:0] OPSUB  = 5'd6;
  localparam logic [OP_W-1:0] OPSLT  = 5'd7;
  localparam logic [OP_W-1:0] OPMUL  = 5'd8;
  localparam logic [OP_W-1:0] OPDIV  = 5'd9;
  localparam logic [OP_W-1:0] OPDIVU = 5'd10;
  localparam logic [OP_W-1:0] OPREM  = 5'd11;
  localparam logic [OP_W-1:0] OPREMU = 5'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Single-cycle ALU ops; anything else (including M ops) yields zero
  function automatic logic [WIDTH-1:0] alu_single(input logic [OP_W-1:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    r = '0;
    case (op)
      OPADD:   r = a + b;
      OPSUB:   r = a - b;
      OPAND:   r = a & b;
      OPOR:    r = a | b;
      OPSLT:   r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic is_iter_op(input logic [OP_W-1:0] op);
    return (op == OPMUL) || (op == OPDIV) || (op == OPDIVU) ||
           (op == OPREM) || (op == OPREMU);
  endfunction

  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op == OPDIV) || (op == OPDIVU) || (op == OPREM) || (op == OPREMU);
  endfunction

endpackage
`endif

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the EX-stage control FSM and the execute unit.
interface alu_exec_unit_if;
  import alu_exec_unit_pkg::*;

  logic             iStart;
  logic [OP_W-1:0]  iALUControl;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic [WIDTH-1:0] oResult;
  logic             oBusy;
  logic             oDone;

  modport master (output iStart, iALUControl, iA, iB,
                  input  oResult, oBusy, oDone);
  modport slave  (input  iStart, iALUControl, iA, iB,
                  output oResult, oBusy, oDone);
endinterface

// File: rtl/alu_iter_muldiv.sv
// Iterative 1-bit-per-cycle engine: shift-add multiply (low WIDTH bits) or
// restoring unsigned divide on operand magnitudes. Built only with RV32M_EN.
module alu_iter_muldiv
  import alu_exec_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done_c,
  output logic [WIDTH-1:0] quo_c,
  output logic [WIDTH-1:0] acc_c
);

  // x: multiplicand / divisor, y: multiplier / dividend->quotient, z: product / remainder
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d, div_q, div_d;
  logic [WIDTH:0]   rem_sh_c, trial_c;

  // One iteration step, or operand load on start
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    div_d    = div_q;
    rem_sh_c = {z_q, y_q[WIDTH-1]};
    trial_c  = rem_sh_c - {1'b0, x_q};
    if (start) begin
      x_d   = is_div ? b : a;
      y_d   = is_div ? a : b;
      z_d   = '0;
      cnt_d = CNT_W'(WIDTH - 1);
      run_d = 1'b1;
      div_d = is_div;
    end else if (run_q) begin
      if (div_q) begin
        if (!trial_c[WIDTH]) begin
          z_d = trial_c[WIDTH-1:0];
          y_d = {y_q[WIDTH-2:0], 1'b1};
        end else begin
          z_d = rem_sh_c[WIDTH-1:0];
          y_d = {y_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        z_d = y_q[0] ? (z_q + x_q) : z_q;
        x_d = x_q << 1;
        y_d = y_q >> 1;
      end
      run_d = (cnt_q != '0);
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  assign done_c = run_q && (cnt_q == '0);
  assign quo_c  = y_d;
  assign acc_c  = z_d;

  // Iteration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      div_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      z_q   <= z_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage execute unit: single-cycle ALU ops, plus iterative MUL/DIV/REM
// when the RV32M_EN macro is defined (otherwise those opcodes return 0).
module alu_exec_unit
  import alu_exec_unit_pkg::*;
(
  input  logic           iCLK,
  input  logic           iRST,
  alu_exec_unit_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;

`ifdef RV32M_EN
  logic             busy_q, busy_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic             start_c, iter_done_c;
  logic             div_op_c, signed_op_c, rem_op_c, a_neg_c, b_neg_c, b_zero_c, ovf_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c, quo_c, acc_c, special_res_c, fix_res_c;

  // Operand magnitudes and divide-by-zero / overflow detection
  always_comb begin
    div_op_c      = is_div_op(bus.iALUControl);
    signed_op_c   = (bus.iALUControl == OPDIV) || (bus.iALUControl == OPREM);
    rem_op_c      = (bus.iALUControl == OPREM) || (bus.iALUControl == OPREMU);
    a_neg_c       = signed_op_c && bus.iA[WIDTH-1];
    b_neg_c       = signed_op_c && bus.iB[WIDTH-1];
    a_mag_c       = a_neg_c ? (WIDTH'(0) - bus.iA) : bus.iA;
    b_mag_c       = b_neg_c ? (WIDTH'(0) - bus.iB) : bus.iB;
    b_zero_c      = (bus.iB == '0);
    ovf_c         = signed_op_c && (bus.iA == SMIN) && (bus.iB == '1);
    special_res_c = '0;
    if (b_zero_c)   special_res_c = rem_op_c ? bus.iA : '1;
    else if (ovf_c) special_res_c = rem_op_c ? '0 : SMIN;
  end

  // Sign fix-up of the iterative result
  always_comb begin
    fix_res_c = acc_c;
    case (op_q)
      OPDIV, OPDIVU: fix_res_c = neg_quo_q ? (WIDTH'(0) - quo_c) : quo_c;
      OPREM, OPREMU: fix_res_c = neg_rem_q ? (WIDTH'(0) - acc_c) : acc_c;
      default:       fix_res_c = acc_c;
    endcase
  end

  alu_iter_muldiv u_iter (
    .clk    (iCLK),
    .rst    (iRST),
    .start  (start_c),
    .is_div (div_op_c),
    .a      (a_mag_c),
    .b      (b_mag_c),
    .done_c (iter_done_c),
    .quo_c  (quo_c),
    .acc_c  (acc_c)
  );

  assign bus.oBusy = busy_q;
`else
  assign bus.oBusy = 1'b0;
`endif

  // Control FSM next state and registered handshake/result
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    done_d   = 1'b0;
`ifdef RV32M_EN
    busy_d    = 1'b0;
    op_d      = op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    start_c   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.iStart) begin
`ifdef RV32M_EN
          if (div_op_c && (b_zero_c || ovf_c)) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = special_res_c;
          end else if (is_iter_op(bus.iALUControl)) begin
            state_d   = ST_RUN;
            busy_d    = 1'b1;
            start_c   = 1'b1;
            op_d      = bus.iALUControl;
            neg_quo_d = a_neg_c ^ b_neg_c;
            neg_rem_d = a_neg_c;
          end else begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = alu_single(bus.iALUControl, bus.iA, bus.iB);
          end
`else
          state_d  = ST_DONE;
          done_d   = 1'b1;
          result_d = alu_single(bus.iALUControl, bus.iA, bus.iB);
`endif
        end
      end
`ifdef RV32M_EN
      ST_RUN: begin
        if (iter_done_c) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          result_d = fix_res_c;
        end else begin
          busy_d = 1'b1;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      done_q    <= 1'b0;
`ifdef RV32M_EN
      busy_q    <= 1'b0;
      op_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      done_q    <= done_d;
`ifdef RV32M_EN
      busy_q    <= busy_d;
      op_q      <= op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign bus.oResult = result_q;
  assign bus.oDone   = done_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit; expectations adapt to whether RV32M_EN is defined.
module tb_alu_exec_unit;
  import alu_exec_unit_pkg::*;

`ifdef RV32M_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif
  localparam int ITER_LAT = 33;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_exec_unit_if bus_if ();

  alu_exec_unit dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;   // expected with the M extension present
    bit          iter;  // runs the iterative datapath
    bit          spec;  // M opcode resolved as a corner case
    int          poke;  // cycle after accept at which a stray iStart is raised (0 = none)
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Caller must be at a negedge; returns at the negedge one cycle after oDone
  task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat,
                       input int poke);
    int          done_at;
    int          busy_cnt;
    int          both;
    logic [31:0] got;
    done_at  = 0;
    busy_cnt = 0;
    both     = 0;
    got      = '0;
    bus_if.iStart      = 1'b1;
    bus_if.iALUControl = op;
    bus_if.iA          = a;
    bus_if.iB          = b;
    @(posedge clk);
    #1;
    bus_if.iStart = 1'b0;
    bus_if.iA     = $urandom;
    bus_if.iB     = $urandom;
    for (int k = 1; k <= 40 && done_at == 0; k++) begin
      @(negedge clk);
      if (bus_if.oBusy) busy_cnt++;
      if (bus_if.oBusy && bus_if.oDone) both++;
      if (bus_if.oDone) begin
        done_at = k;
        got     = bus_if.oResult;
      end
      if (k == poke) begin
        bus_if.iStart      = 1'b1;
        bus_if.iALUControl = OPADD;
      end
      if (k == poke + 1) bus_if.iStart = 1'b0;
    end
    check({tag, " latency"}, 32'(done_at), 32'(lat));
    check({tag, " result"}, got, exp);
    check({tag, " busy cycles"}, 32'(busy_cnt), 32'(lat - 1));
    check({tag, " busy/done overlap"}, 32'(both), 32'd0);
    @(negedge clk);
    bus_if.iStart = 1'b0;
    check({tag, " hold"}, {bus_if.oDone, bus_if.oResult[30:0]}, {1'b0, exp[30:0]});
    check({tag, " hold msb"}, {31'd0, bus_if.oResult[31]}, {31'd0, exp[31]});
  endtask

  initial begin
    int dones;
    bus_if.iStart      = 1'b0;
    bus_if.iALUControl = OPADD;
    bus_if.iA          = '0;
    bus_if.iB          = '0;

    // Reset, then idle
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset oResult", bus_if.oResult, 32'd0);
    check("reset oBusy", {31'd0, bus_if.oBusy}, 32'd0);
    check("reset oDone", {31'd0, bus_if.oDone}, 32'd0);
    rst   = 1'b0;
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus_if.oDone) dones++;
    end
    check("idle no done", 32'(dones), 32'd0);

    vecs[0]  = '{OPADD,  32'd1,          32'd2,          32'd3,          1'b0, 1'b0, 0};
    vecs[1]  = '{OPSUB,  32'd5,          32'd7,          32'hFFFFFFFE,   1'b0, 1'b0, 1};
    vecs[2]  = '{OPSLT,  32'hFFFFFFFF,   32'd1,          32'd1,          1'b0, 1'b0, 0};
    vecs[3]  = '{OPSLT,  32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 1'b0, 0};
    vecs[4]  = '{OPAND,  32'hF0F01234,   32'h0FF0FF00,   32'h00F01200,   1'b0, 1'b0, 0};
    vecs[5]  = '{OPOR,   32'hF000000F,   32'h0000F0F0,   32'hF000F0FF,   1'b0, 1'b0, 0};
    vecs[6]  = '{OPADD,  32'hFFFFFFFF,   32'd1,          32'd0,          1'b0, 1'b0, 0};
    vecs[7]  = '{5'h1F,  32'd123,        32'd456,        32'd0,          1'b0, 1'b0, 0};
    vecs[8]  = '{OPMUL,  32'h00010001,   32'h00010001,   32'h00020001,   1'b1, 1'b0, 5};
    vecs[9]  = '{OPMUL,  32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          1'b1, 1'b0, 0};
    vecs[10] = '{OPDIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   1'b1, 1'b0, 0};
    vecs[11] = '{OPREM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   1'b1, 1'b0, 0};
    vecs[12] = '{OPDIVU, 32'd7,          32'd2,          32'd3,          1'b1, 1'b0, 0};
    vecs[13] = '{OPREMU, 32'd7,          32'd2,          32'd1,          1'b1, 1'b0, 0};
    vecs[14] = '{OPDIV,  32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   1'b1, 1'b0, 0};
    vecs[15] = '{OPREM,  32'd7,          32'hFFFFFFFE,   32'd1,          1'b1, 1'b0, 0};
    vecs[16] = '{OPDIVU, 32'h12345678,   32'd0,          32'hFFFFFFFF,   1'b0, 1'b1, 1};
    vecs[17] = '{OPREM,  32'd9,          32'd0,          32'd9,          1'b0, 1'b1, 0};
    vecs[18] = '{OPDIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b0, 1'b1, 0};
    vecs[19] = '{OPREM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          1'b0, 1'b1, 0};
    vecs[20] = '{OPDIVU, 32'hFFFFFFFF,   32'h00000010,   32'h0FFFFFFF,   1'b1, 1'b0, 0};
    vecs[21] = '{OPREMU, 32'hFFFFFFFF,   32'h00000010,   32'h0000000F,   1'b1, 1'b0, 0};
    vecs[22] = '{OPDIV,  32'h80000000,   32'd2,          32'hC0000000,   1'b1, 1'b0, 0};
    vecs[23] = '{OPSUB,  32'd0,          32'd1,          32'hFFFFFFFF,   1'b0, 1'b0, 0};

    for (int i = 0; i < 24; i++) begin
      logic [31:0] exp;
      int          lat;
      exp = (!M_EN && (vecs[i].iter || vecs[i].spec)) ? 32'd0 : vecs[i].exp;
      lat = (M_EN && vecs[i].iter) ? ITER_LAT : 1;
      do_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, exp, lat, vecs[i].poke);
    end

    // Reset in the middle of a multiply discards it
    bus_if.iStart      = 1'b1;
    bus_if.iALUControl = OPMUL;
    bus_if.iA          = 32'h00010001;
    bus_if.iB          = 32'h00010001;
    @(posedge clk);
    #1;
    bus_if.iStart = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 10) rst = 1'b1;
    end
    @(negedge clk);
    check("midrst oBusy", {31'd0, bus_if.oBusy}, 32'd0);
    check("midrst oResult", bus_if.oResult, 32'd0);
    check("midrst oDone", {31'd0, bus_if.oDone}, 32'd0);
    rst   = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus_if.oDone) dones++;
    end
    check("midrst no done", 32'(dones), 32'd0);
    do_op("post-reset add", OPADD, 32'd1, 32'd2, 32'd3, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
